// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU/RAM instruction sequencer.
// The instruction field positions, FSM states, condition codes and comparator
// flag indices live here so the FIFO, the top and the bench all agree.
package alu_seq_pkg;

  // Instruction field positions: [31:30] cond, [29] wb, [28:25] opcode,
  // [24] cin, [23:16] addr_a, [15:8] addr_b, [7:0] addr_z.
  localparam int COND_MSB = 31;
  localparam int COND_LSB = 30;
  localparam int WB_BIT   = 29;
  localparam int OP_MSB   = 28;
  localparam int OP_LSB   = 25;
  localparam int CIN_BIT  = 24;
  localparam int A_MSB    = 23;
  localparam int A_LSB    = 16;
  localparam int B_MSB    = 15;
  localparam int B_LSB    = 8;
  localparam int Z_MSB    = 7;
  localparam int Z_LSB    = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_XEY    = 2'b01;
  localparam logic [1:0] COND_XBY    = 2'b10;
  localparam logic [1:0] COND_YBX    = 2'b11;

  // Comparator flags arrive as {XBY, YBX, XEY}.
  localparam int FLAG_XBY = 2;
  localparam int FLAG_YBX = 1;
  localparam int FLAG_XEY = 0;

  // Selects the comparator flag that gates a conditional write-back.
  function automatic logic cond_met(input logic [1:0] cond, input logic [2:0] flags);
    logic met;
    case (cond)
      COND_ALWAYS: met = 1'b1;
      COND_XEY:    met = flags[FLAG_XEY];
      COND_XBY:    met = flags[FLAG_XBY];
      COND_YBX:    met = flags[FLAG_YBX];
      default:     met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/alu_ram_sequencer_if.sv
// Instruction-in and result-out handshake bundle of the ALU/RAM sequencer.
// master = producer of instructions / consumer of results, slave = sequencer.
interface alu_ram_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_z;
  logic [2:0]  res_flags;
  logic        res_wrote;

  modport master (
    output in_valid, in_instr, res_ready,
    input  in_ready, res_valid, res_z, res_flags, res_wrote
  );

  modport slave (
    input  in_valid, in_instr, res_ready,
    output in_ready, res_valid, res_z, res_flags, res_wrote
  );
endinterface

// File: rtl/alu_seq_fifo.sv
// Instruction FIFO: first-word fall-through, power-of-two depth so the
// pointers wrap naturally. A push is refused whenever the FIFO is full,
// even if a pop happens in the same cycle.
module alu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == FULL_COUNT);
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/alu_ram_sequencer.sv
// Instruction sequencer in front of the dual-port-RAM/ALU datapath.
// Buffers instructions, issues them one at a time (ISSUE -> CAPTURE -> WRITE
// -> DONE) and holds each result until the consumer takes it.
// Optional build macro ALU_SEQ_COND_WRITE_EN: gate write-back on the
// instruction's cond field against the captured comparator flags.
module alu_ram_sequencer
  import alu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int INSTR_W    = 32
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  alu_ram_sequencer_if.slave          bus,
  output logic [7:0]                  Addr_A,
  output logic [7:0]                  Addr_B,
  output logic [3:0]                  Opcode,
  output logic                        Cin,
  output logic [7:0]                  Addr_Z,
  output logic                        WE_Z,
  input  logic [7:0]                  Z_In,
  input  logic [2:0]                  Flags_In,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  state_t             state_r;
  logic [INSTR_W-1:0] head_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               pop_s;
  logic               wb_r;
  logic [1:0]         cond_r;
  logic               do_write_s;
  logic               res_valid_r;
  logic [7:0]         res_z_r;
  logic [2:0]         res_flags_r;
  logic               res_wrote_r;

  assign pop_s         = (state_r == ST_IDLE) && !fifo_empty_s;
  assign bus.in_ready  = ~fifo_full_s;
  assign busy          = (state_r != ST_IDLE);
  assign bus.res_valid = res_valid_r;
  assign bus.res_z     = res_z_r;
  assign bus.res_flags = res_flags_r;
  assign bus.res_wrote = res_wrote_r;

  alu_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (bus.in_valid),
    .din   (bus.in_instr),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count)
  );

`ifdef ALU_SEQ_COND_WRITE_EN
  // Write-back only when wb is set and the selected comparator flag is true.
  always_comb begin
    do_write_s = 1'b0;
    if (wb_r) begin
      do_write_s = cond_met(cond_r, Flags_In);
    end else begin
      do_write_s = 1'b0;
    end
  end
`else
  logic unused_cond_s;
  assign unused_cond_s = ^cond_r;

  // Write-back follows wb alone; the cond field behaves as "always".
  always_comb begin
    do_write_s = 1'b0;
    if (wb_r) begin
      do_write_s = 1'b1;
    end else begin
      do_write_s = 1'b0;
    end
  end
`endif

  // Sequencing FSM with registered datapath controls and result registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= ST_IDLE;
      Addr_A      <= 8'h00;
      Addr_B      <= 8'h00;
      Opcode      <= 4'h0;
      Cin         <= 1'b0;
      Addr_Z      <= 8'h00;
      WE_Z        <= 1'b0;
      wb_r        <= 1'b0;
      cond_r      <= 2'b00;
      res_valid_r <= 1'b0;
      res_z_r     <= 8'h00;
      res_flags_r <= 3'b000;
      res_wrote_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Controls are loaded at the pop so they are already valid in ISSUE.
          if (!fifo_empty_s) begin
            Addr_A  <= head_s[A_MSB:A_LSB];
            Addr_B  <= head_s[B_MSB:B_LSB];
            Opcode  <= head_s[OP_MSB:OP_LSB];
            Cin     <= head_s[CIN_BIT];
            Addr_Z  <= head_s[Z_MSB:Z_LSB];
            wb_r    <= head_s[WB_BIT];
            cond_r  <= head_s[COND_MSB:COND_LSB];
            state_r <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // Settle cycle for the combinational RAM read and ALU.
          state_r <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          res_z_r     <= Z_In;
          res_flags_r <= Flags_In;
          WE_Z        <= do_write_s;
          res_wrote_r <= do_write_s;
          state_r     <= ST_WRITE;
        end
        ST_WRITE: begin
          WE_Z        <= 1'b0;
          res_valid_r <= 1'b1;
          state_r     <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            res_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_DONE;
          end
        end
        default: begin
          WE_Z        <= 1'b0;
          res_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ram_sequencer.sv
// Directed bench for alu_ram_sequencer with a RAM + adder datapath model.
module tb_alu_ram_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] addr_a, addr_b, addr_z, z_in;
  logic [3:0] opcode;
  logic       cin, we_z, busy;
  logic [2:0] flags_in;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  int we_pulses = 0;

  always #5 clk = ~clk;

  alu_ram_sequencer_if bus_if ();

  alu_ram_sequencer dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .bus        (bus_if),
    .Addr_A     (addr_a),
    .Addr_B     (addr_b),
    .Opcode     (opcode),
    .Cin        (cin),
    .Addr_Z     (addr_z),
    .WE_Z       (we_z),
    .Z_In       (z_in),
    .Flags_In   (flags_in),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // Datapath model: RAM with combinational read and clocked write, adder ALU.
  logic [7:0] ram [0:255];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = 8'h00;
  logic [7:0] pl_data = 8'h00;
  logic [7:0] a_v, b_v;

  always @(posedge clk) begin
    if (we_z === 1'b1) ram[addr_z] <= z_in;
    else if (pl_en) ram[pl_addr] <= pl_data;
  end

  always @(posedge clk) begin
    if (we_z === 1'b1) we_pulses <= we_pulses + 1;
  end

  always_comb begin
    a_v = ram[addr_a];
    b_v = ram[addr_b];
    z_in = (opcode == 4'h0) ? (a_v + b_v + {7'd0, cin}) : 8'h00;
    flags_in = {(a_v > b_v), (b_v > a_v), (a_v == b_v)};
  end

  function automatic logic [31:0] mk(input logic [1:0] cond, input logic wb, input logic [3:0] op,
                                     input logic c, input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] z);
    return {cond, wb, op, c, a, b, z};
  endfunction

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Offer one instruction (called at a negedge); returns at the negedge after acceptance.
  task automatic offer(input logic [31:0] instr, output bit ok);
    ok = 1'b0;
    bus_if.in_valid = 1'b1;
    bus_if.in_instr = instr;
    for (int i = 0; i < 50; i++) begin
      if (bus_if.in_ready === 1'b1) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus_if.in_valid = 1'b0;
  endtask

  // Wait (bounded) for a result, grab it and hand back a one-cycle res_ready.
  task automatic collect(output logic [7:0] z, output logic [2:0] f, output logic w, output bit ok);
    ok = 1'b0; z = 8'h00; f = 3'b000; w = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus_if.res_valid === 1'b1) begin
        z = bus_if.res_z; f = bus_if.res_flags; w = bus_if.res_wrote;
        ok = 1'b1;
        bus_if.res_ready = 1'b1;
        @(negedge clk);
        bus_if.res_ready = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({addr_a, addr_b, opcode, cin, addr_z, we_z} !== 30'd0) begin
      n_fail++; $display("FAIL reset_datapath: got %h want 0", {addr_a, addr_b, opcode, cin, addr_z, we_z});
    end
    n_checks++;
    if ({bus_if.res_valid, bus_if.res_z, bus_if.res_flags, bus_if.res_wrote, busy, fifo_count} !== 17'd0) begin
      n_fail++; $display("FAIL reset_result: got %h want 0",
        {bus_if.res_valid, bus_if.res_z, bus_if.res_flags, bus_if.res_wrote, busy, fifo_count});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok; int w0;
    preload(8'h10, 8'h25);
    preload(8'h11, 8'h13);
    preload(8'h20, 8'h00);
    w0 = we_pulses;
    offer(mk(2'b00, 1'b1, 4'h0, 1'b1, 8'h10, 8'h11, 8'h20), ok);
    // Cycle t: instruction sits in FIFO, FSM idle, pop at the coming edge.
    n_checks++;
    if (!ok || fifo_count !== 3'd1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_pop_cycle: ok=%0d count=%0d busy=%b want 1/1/0", ok, fifo_count, busy);
    end
    @(negedge clk);  // t+1 ISSUE
    n_checks++;
    if ({addr_a, addr_b, addr_z, cin} !== {8'h10, 8'h11, 8'h20, 1'b1} || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_issue: got a=%h b=%h z=%h cin=%b busy=%b", addr_a, addr_b, addr_z, cin, busy);
    end
    @(negedge clk);  // t+2 CAPTURE
    n_checks++;
    if (we_z !== 1'b0) begin
      n_fail++; $display("FAIL basic_we_early: got %b want 0", we_z);
    end
    @(negedge clk);  // t+3 WRITE
    n_checks++;
    if (we_z !== 1'b1 || addr_z !== 8'h20 || bus_if.res_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_write: we=%b addr_z=%h res_valid=%b want 1/20/0", we_z, addr_z, bus_if.res_valid);
    end
    @(negedge clk);  // t+4 DONE
    n_checks++;
    if (we_z !== 1'b0 || bus_if.res_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_done: we=%b res_valid=%b want 0/1", we_z, bus_if.res_valid);
    end
    n_checks++;
    if ({bus_if.res_z, bus_if.res_flags, bus_if.res_wrote} !== {8'h39, 3'b100, 1'b1}) begin
      n_fail++; $display("FAIL basic_result: got z=%h f=%b w=%b want 39/100/1",
        bus_if.res_z, bus_if.res_flags, bus_if.res_wrote);
    end
    n_checks++;
    if (ram[8'h20] !== 8'h39 || (we_pulses - w0) != 1) begin
      n_fail++; $display("FAIL basic_ram: got ram=%h pulses=%0d want 39/1", ram[8'h20], we_pulses - w0);
    end
    bus_if.res_ready = 1'b1;
    @(negedge clk);
    bus_if.res_ready = 1'b0;
    n_checks++;
    if (bus_if.res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_release: res_valid=%b busy=%b want 0/0", bus_if.res_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, okr; logic [7:0] z; logic [2:0] f; logic w;
    offer(mk(2'b00, 1'b1, 4'h0, 1'b0, 8'h20, 8'h20, 8'h21), ok1);
    offer(mk(2'b00, 1'b1, 4'h0, 1'b0, 8'h21, 8'h10, 8'h22), ok2);
    collect(z, f, w, okr);
    n_checks++;
    if (!(ok1 && ok2 && okr) || {z, f, w} !== {8'h72, 3'b001, 1'b1}) begin
      n_fail++; $display("FAIL b2b_first: ok=%0d%0d%0d z=%h f=%b w=%b want 72/001/1", ok1, ok2, okr, z, f, w);
    end
    collect(z, f, w, okr);
    n_checks++;
    if (!okr || {z, f, w} !== {8'h97, 3'b100, 1'b1}) begin
      n_fail++; $display("FAIL b2b_dependent: ok=%0d z=%h f=%b w=%b want 97/100/1", okr, z, f, w);
    end
    n_checks++;
    if (ram[8'h21] !== 8'h72 || ram[8'h22] !== 8'h97) begin
      n_fail++; $display("FAIL b2b_ram: got %h %h want 72 97", ram[8'h21], ram[8'h22]);
    end
  endtask

  task automatic test_backpressure();
    bit ok, okr; int accepted; int w0; logic [7:0] z; logic [2:0] f; logic w;
    for (int k = 0; k < 5; k++) preload(8'h30 + 8'(k), 8'(k + 1));
    w0 = we_pulses;
    accepted = 0;
    for (int k = 0; k < 5; k++) begin
      offer(mk(2'b00, 1'b0, 4'h0, 1'b0, 8'h10, 8'h30 + 8'(k), 8'h70), ok);
      if (ok) accepted++;
    end
    n_checks++;
    if (accepted != 5 || fifo_count !== 3'd4 || bus_if.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_full: accepted=%0d count=%0d in_ready=%b want 5/4/0",
        accepted, fifo_count, bus_if.in_ready);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (fifo_count !== 3'd4 || bus_if.res_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold: count=%0d res_valid=%b busy=%b want 4/1/1", fifo_count, bus_if.res_valid, busy);
    end
    // Offer a sixth while full; the pop that follows must not let it in.
    bus_if.in_valid = 1'b1;
    bus_if.in_instr = mk(2'b00, 1'b0, 4'h0, 1'b0, 8'h10, 8'h10, 8'h70);
    for (int k = 0; k < 5; k++) begin
      collect(z, f, w, okr);
      if (k == 0) begin
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        n_checks++;
        if (fifo_count !== 3'd3) begin
          n_fail++; $display("FAIL bp_full_refuse: count=%0d want 3", fifo_count);
        end
      end
      n_checks++;
      if (!okr || {z, f, w} !== {8'h26 + 8'(k), 3'b100, 1'b0}) begin
        n_fail++; $display("FAIL bp_order%0d: ok=%0d z=%h f=%b w=%b want %h/100/0", k, okr, z, f, w, 8'h26 + 8'(k));
      end
    end
    n_checks++;
    if (fifo_count !== 3'd0 || (we_pulses - w0) != 0) begin
      n_fail++; $display("FAIL bp_drain: count=%0d pulses=%0d want 0/0", fifo_count, we_pulses - w0);
    end
  endtask

  task automatic test_reset_midop();
    bit ok1, ok2, found; int w0;
    preload(8'h40, 8'h5A);
    w0 = we_pulses;
    offer(mk(2'b00, 1'b1, 4'h0, 1'b1, 8'h10, 8'h11, 8'h40), ok1);
    offer(mk(2'b00, 1'b1, 4'h0, 1'b1, 8'h10, 8'h11, 8'h41), ok2);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (we_z === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!(ok1 && ok2 && found)) begin
      n_fail++; $display("FAIL rst_reach_write: ok=%0d%0d found=%0d want 111", ok1, ok2, found);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (we_z !== 1'b0 || fifo_count !== 3'd0 || bus_if.res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: we=%b count=%0d res_valid=%b busy=%b want 0/0/0/0",
        we_z, fifo_count, bus_if.res_valid, busy);
    end
    @(negedge clk);
    n_checks++;
    if (ram[8'h40] !== 8'h5A || (we_pulses - w0) != 0) begin
      n_fail++; $display("FAIL rst_no_write: ram=%h pulses=%0d want 5a/0", ram[8'h40], we_pulses - w0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL rst_after: busy=%b count=%0d want 0/0", busy, fifo_count);
    end
  endtask

  task automatic test_wb0();
    bit ok, okr; int w0; logic [7:0] z; logic [2:0] f; logic w;
    preload(8'h50, 8'h77);
    w0 = we_pulses;
    offer(mk(2'b00, 1'b0, 4'h0, 1'b1, 8'h10, 8'h11, 8'h50), ok);
    collect(z, f, w, okr);
    n_checks++;
    if (!(ok && okr) || {z, f, w} !== {8'h39, 3'b100, 1'b0}) begin
      n_fail++; $display("FAIL wb0_result: ok=%0d%0d z=%h f=%b w=%b want 39/100/0", ok, okr, z, f, w);
    end
    n_checks++;
    if (ram[8'h50] !== 8'h77 || (we_pulses - w0) != 0) begin
      n_fail++; $display("FAIL wb0_nowrite: ram=%h pulses=%0d want 77/0", ram[8'h50], we_pulses - w0);
    end
  endtask

  task automatic test_cond();
    bit ok, okr; int w0; logic [7:0] z; logic [2:0] f; logic w;
    logic       exp_w;
    logic [7:0] exp_ram;
    int         exp_pulses;
`ifdef ALU_SEQ_COND_WRITE_EN
    exp_w = 1'b0; exp_ram = 8'hEE; exp_pulses = 0;
`else
    exp_w = 1'b1; exp_ram = 8'h0B; exp_pulses = 1;
`endif
    preload(8'h60, 8'h05);
    preload(8'h61, 8'h06);
    preload(8'h62, 8'hEE);
    w0 = we_pulses;
    offer(mk(2'b01, 1'b1, 4'h0, 1'b0, 8'h60, 8'h61, 8'h62), ok);
    collect(z, f, w, okr);
    n_checks++;
    if (!(ok && okr) || {z, f, w} !== {8'h0B, 3'b010, exp_w}) begin
      n_fail++; $display("FAIL cond_result: ok=%0d%0d z=%h f=%b w=%b want 0b/010/%b", ok, okr, z, f, w, exp_w);
    end
    n_checks++;
    if (ram[8'h62] !== exp_ram || (we_pulses - w0) != exp_pulses) begin
      n_fail++; $display("FAIL cond_write: ram=%h pulses=%0d want %h/%0d", ram[8'h62], we_pulses - w0, exp_ram, exp_pulses);
    end
  endtask

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.in_instr  = 32'h0;
    bus_if.res_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    test_wb0();
    test_cond();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_ram_sequencer.md
Name: alu_ram_sequencer

Overview:
Instruction sequencer directly upstream of the dual-port-RAM/ALU datapath. Accepts packed three-address instructions on a valid/ready input and buffers them in a small FIFO. Drives Addr_A, Addr_B, Opcode, Cin, Addr_Z and WE_Z into the datapath one instruction at a time, then captures Z_Out and Comparator_Flags into a result register presented on a valid/ready output.
Datapath contract: RAM read is combinational; RAM write is on the CLK rising edge when WE_Z=1.

Parameters:
FIFO_DEPTH, 4, instruction FIFO entries; power of two, minimum 2
INSTR_W, 32, instruction width; fixed layout below, not overridable in practice

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
in_valid  in  1  instruction offered
in_ready  out  1  FIFO not full
in_instr  in  32  [31:30] cond, [29] wb, [28:25] opcode, [24] cin, [23:16] addr_a, [15:8] addr_b, [7:0] addr_z
Addr_A  out  8  to datapath
Addr_B  out  8  to datapath
Opcode  out  4  to datapath
Cin  out  1  to datapath
Addr_Z  out  8  to datapath
WE_Z  out  1  one-cycle write strobe to datapath
Z_In  in  8  datapath Z_Out
Flags_In  in  3  datapath Comparator_Flags {XBY,YBX,XEY}
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_z  out  8  captured Z
res_flags  out  3  captured flags
res_wrote  out  1  1 if WE_Z was pulsed for this instruction
busy  out  1  FSM not IDLE
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries

Behaviour:
- Clock and reset: single clock CLK; reset RST_N is asynchronous, active-low.
- Reset: every output goes to 0 immediately, FSM goes to IDLE, FIFO is emptied. WE_Z drops asynchronously.
- Reset mid-instruction: the in-flight instruction is discarded with no write.
- Push: occurs on in_valid & in_ready; in_ready = (fifo_count != FIFO_DEPTH).
- When full, a push is refused even if a pop occurs in the same cycle.
- A push and a pop in the same cycle on a non-full FIFO leave the count unchanged.
- The FIFO is first-word fall-through internally; pointers wrap modulo FIFO_DEPTH.
- FSM states are IDLE, ISSUE, CAPTURE, WRITE, DONE.
  - IDLE: if the FIFO is non-empty, pop the head into the instruction register and go to ISSUE. Otherwise stay.
  - ISSUE: drive Addr_A/B/Z, Opcode and Cin from the instruction register; these hold stable through DONE. Next state is CAPTURE, giving one settle cycle.
  - CAPTURE: register Z_In into res_z and Flags_In into res_flags. Evaluate do_write (see below). Go to WRITE.
  - WRITE: WE_Z = do_write for exactly this cycle; res_wrote = do_write. Go to DONE.
  - DONE: res_valid=1. On res_ready, go to IDLE; res_valid falls on the next cycle.
- do_write = wb (condition field ignored, base build).
- Latency: a pop in IDLE at cycle t gives WE_Z in cycle t+3 and res_valid from cycle t+4.
- Throughput: at best one instruction per 5 cycles.
- Ordering: the RAM write completes before the next ISSUE. A following instruction reading addr_z therefore sees the new value, with no hazard logic.
- Between instructions, the address and opcode outputs hold their last values; WE_Z=0 outside WRITE.
- res_* hold their value until the next CAPTURE.
- busy = (state != IDLE).

Optional Feature:
ALU_SEQ_COND_WRITE_EN
- Defined: do_write = wb & cond_met, with cond_met selected by cond:
  - 00 always
  - 01 XEY
  - 10 XBY
  - 11 YBX
  All flags are taken from the Flags_In captured in CAPTURE. A suppressed write leaves res_valid unaffected, with res_wrote=0.
- Undefined: the cond bits are ignored and behave as 00.

Decomposition:
- Package alu_seq_pkg holds:
  - instruction field LSB/MSB constants
  - state enum (IDLE, ISSUE, CAPTURE, WRITE, DONE)
  - cond codes
  - flag bit indices (XBY=2, YBX=1, XEY=0)
- Sub-module alu_seq_fifo: a parameterised synchronous FIFO with an async active-low reset, count output, and full/empty flags.
- The FSM and result registers live in the top module.

Test Plan:
- The bench model implements RAM (comb read, clocked write) plus Z = A+B+Cin for opcode 4'h0, with the flags computed as A>B, B>A, A==B.
- Preload RAM[0x10]=0x25, RAM[0x11]=0x13. Push {cond=00, wb=1, op=0, cin=1, A=0x10, B=0x11, Z=0x20}. Required: WE_Z pulses once with Addr_Z=0x20 3 cycles after pop; res_z=0x39, res_flags=3'b100, res_wrote=1; RAM[0x20]=0x39.
- Back-to-back dependency: the second instruction reads A=0x20, B=0x20, Z=0x21, cin=0. Required: res_z=0x72, flags=3'b001.
- Backpressure: push 5 instructions with res_ready=0 and FIFO_DEPTH=4. Required:
  - the first is popped;
  - in_ready drops when fifo_count=4;
  - results emerge in push order once res_ready=1;
  - no result is lost.
- Reset mid-op: assert RST_N=0 during WRITE. Required: WE_Z goes 0 asynchronously, fifo_count=0, res_valid=0, and the RAM target is unchanged.
- With ALU_SEQ_COND_WRITE_EN and cond=01 (XEY) on A=0x05, B=0x06. Required: WE_Z never asserts, res_wrote=0, res_valid=1, res_flags=3'b010.
- wb=0 in either build. Required: no WE_Z; the result is still delivered.
